// File: rtl/logic_axi4_stream_packet_buffer.sv
// rtl/logic_axi4_stream_packet_buffer.sv - AXI4-Stream FIFO with cut-through or store-and-forward release
//
// Purpose: single-clock stream buffer of CAPACITY beats. In packet mode a
// packet is only presented once its tlast beat is stored. An oversize packet
// that fills the buffer without a tlast forces cut-through release instead of
// deadlocking.
//
// Ports:
//   aclk, areset_n     clock, asynchronous active-low reset
//   rx_t*              input stream (tdata/tstrb/tkeep/tlast/tid/tdest/tuser/tvalid/tready)
//   tx_t*              output stream (same fields)
//   level              stored beats
//   packets            stored tlast beats
//   overflow           sticky flag: an oversize packet forced release

package logic_pkg;
    typedef enum int {
        TARGET_GENERIC,
        TARGET_XILINX,
        TARGET_INTEL
    } target_t;
endpackage

module logic_axi4_stream_packet_buffer #(
    parameter int                 TDATA_BYTES = 1,
    parameter int                 TDEST_WIDTH = 1,
    parameter int                 TUSER_WIDTH = 1,
    parameter int                 TID_WIDTH   = 1,
    parameter bit                 USE_TLAST   = 1,
    parameter bit                 USE_TKEEP   = 1,
    parameter bit                 USE_TSTRB   = 1,
    parameter int                 CAPACITY    = 16,
    parameter bit                 PACKET_MODE = 0,
    parameter logic_pkg::target_t TARGET      = logic_pkg::TARGET_GENERIC,
    localparam int                CW          = $clog2(CAPACITY + 1)
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic [8*TDATA_BYTES-1:0]   rx_tdata,
    input  logic [TDATA_BYTES-1:0]     rx_tstrb,
    input  logic [TDATA_BYTES-1:0]     rx_tkeep,
    input  logic                       rx_tlast,
    input  logic [TID_WIDTH-1:0]       rx_tid,
    input  logic [TDEST_WIDTH-1:0]     rx_tdest,
    input  logic [TUSER_WIDTH-1:0]     rx_tuser,
    input  logic                       rx_tvalid,
    output logic                       rx_tready,
    output logic [8*TDATA_BYTES-1:0]   tx_tdata,
    output logic [TDATA_BYTES-1:0]     tx_tstrb,
    output logic [TDATA_BYTES-1:0]     tx_tkeep,
    output logic                       tx_tlast,
    output logic [TID_WIDTH-1:0]       tx_tid,
    output logic [TDEST_WIDTH-1:0]     tx_tdest,
    output logic [TUSER_WIDTH-1:0]     tx_tuser,
    output logic                       tx_tvalid,
    input  logic                       tx_tready,
    output logic [CW-1:0]              level,
    output logic [CW-1:0]              packets,
    output logic                       overflow
);

    localparam int DW = 8 * TDATA_BYTES;
    localparam int PW = DW + 2 * TDATA_BYTES + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;
    localparam int AW = $clog2(CAPACITY);

    logic [PW-1:0]   mem [CAPACITY];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   level_q, packets_q;
    logic            ready_en, forced_q, overflow_q;
    logic [PW-1:0]   w_beat, r_beat;
    logic            w_last, r_last;
    logic            wr_en, rd_en, force_set, release_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(CAPACITY - 1)) ? '0 : p + 1'b1;
    endfunction

    // Disabled sideband fields are stored as constants so they read back as
    // ones and synthesis trims the corresponding storage.
    assign w_last = USE_TLAST ? rx_tlast : 1'b1;
    assign w_beat = {rx_tdata,
                     USE_TSTRB ? rx_tstrb : {TDATA_BYTES{1'b1}},
                     USE_TKEEP ? rx_tkeep : {TDATA_BYTES{1'b1}},
                     w_last, rx_tid, rx_tdest, rx_tuser};

    assign {tx_tdata, tx_tstrb, tx_tkeep, r_last, tx_tid, tx_tdest, tx_tuser} = r_beat;
    assign tx_tlast = r_last;

    // A full buffer with no complete packet can never release on its own.
    assign force_set  = PACKET_MODE && (level_q == CW'(CAPACITY)) && (packets_q == '0);
    assign release_ok = !PACKET_MODE || (packets_q != '0) || forced_q || force_set;

    // ready_en keeps rx_tready low until the first edge after reset release.
    assign rx_tready = ready_en && (level_q != CW'(CAPACITY));
    assign tx_tvalid = (level_q != '0) && release_ok;
    assign wr_en     = rx_tvalid && rx_tready;
    assign rd_en     = tx_tvalid && tx_tready;

    assign level    = level_q;
    assign packets  = packets_q;
    assign overflow = overflow_q || force_set;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            packets_q  <= '0;
            ready_en   <= 1'b0;
            forced_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            case ({wr_en && w_last, rd_en && r_last})
                2'b10:   packets_q <= packets_q + 1'b1;
                2'b01:   packets_q <= packets_q - 1'b1;
                default: packets_q <= packets_q;
            endcase
            // Forced release lasts until the oversize packet's tlast leaves.
            if (rd_en && r_last) forced_q <= 1'b0;
            else if (force_set)  forced_q <= 1'b1;
            if (force_set) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= w_beat;
    end

    generate
        if (TARGET == logic_pkg::TARGET_GENERIC) begin : g_regs
            assign r_beat = mem[rd_ptr];
        end else begin : g_sync_mem
            // Synchronous-read memory: fetch the head for the next cycle one
            // edge early, bypassing a same-edge write to that address, so the
            // visible timing matches the register array.
            logic [AW-1:0] rd_ptr_next;
            logic [PW-1:0] r_q;
            assign rd_ptr_next = rd_en ? next_ptr(rd_ptr) : rd_ptr;
            always_ff @(posedge aclk) begin
                r_q <= (wr_en && (wr_ptr == rd_ptr_next)) ? w_beat : mem[rd_ptr_next];
            end
            assign r_beat = r_q;
        end
    endgenerate

endmodule

// File: tb/tb_logic_axi4_stream_packet_buffer.sv
// tb/tb_logic_axi4_stream_packet_buffer.sv - randomized bench with queue-style reference model
module tb_logic_axi4_stream_packet_buffer;

    localparam int ND = 3;

    logic        aclk;
    logic        areset_n;
    logic [15:0] rx_tdata;
    logic [1:0]  rx_tstrb, rx_tkeep, rx_tid, rx_tdest;
    logic [2:0]  rx_tuser;
    logic        rx_tlast, rx_tvalid, tx_tready;

    logic        rdy   [ND];
    logic        vld   [ND];
    logic [15:0] t_data[ND];
    logic [1:0]  t_strb[ND], t_keep[ND], t_id[ND], t_dest[ND];
    logic [2:0]  t_user[ND];
    logic        t_last[ND];
    logic [3:0]  lvl   [ND];
    logic [3:0]  pkt   [ND];
    logic        ovf   [ND];
    logic [2:0]  lvl2, pkt2;

    assign lvl[2] = {1'b0, lvl2};
    assign pkt[2] = {1'b0, pkt2};

    // DUT 0: cut-through, 8 beats. DUT 1: store-and-forward, 8 beats.
    // DUT 2: store-and-forward with tlast/tkeep/tstrb removed, 7 beats.
    int cap_c [ND] = '{8, 8, 7};
    bit pm_c  [ND] = '{1'b0, 1'b1, 1'b1};

    logic_axi4_stream_packet_buffer #(
        .TDATA_BYTES(2), .TDEST_WIDTH(2), .TUSER_WIDTH(3), .TID_WIDTH(2),
        .CAPACITY(8), .PACKET_MODE(1'b0)
    ) u_ct (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
        .rx_tid(rx_tid), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
        .rx_tvalid(rx_tvalid), .rx_tready(rdy[0]),
        .tx_tdata(t_data[0]), .tx_tstrb(t_strb[0]), .tx_tkeep(t_keep[0]), .tx_tlast(t_last[0]),
        .tx_tid(t_id[0]), .tx_tdest(t_dest[0]), .tx_tuser(t_user[0]),
        .tx_tvalid(vld[0]), .tx_tready(tx_tready),
        .level(lvl[0]), .packets(pkt[0]), .overflow(ovf[0])
    );

    logic_axi4_stream_packet_buffer #(
        .TDATA_BYTES(2), .TDEST_WIDTH(2), .TUSER_WIDTH(3), .TID_WIDTH(2),
        .CAPACITY(8), .PACKET_MODE(1'b1)
    ) u_sf (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
        .rx_tid(rx_tid), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
        .rx_tvalid(rx_tvalid), .rx_tready(rdy[1]),
        .tx_tdata(t_data[1]), .tx_tstrb(t_strb[1]), .tx_tkeep(t_keep[1]), .tx_tlast(t_last[1]),
        .tx_tid(t_id[1]), .tx_tdest(t_dest[1]), .tx_tuser(t_user[1]),
        .tx_tvalid(vld[1]), .tx_tready(tx_tready),
        .level(lvl[1]), .packets(pkt[1]), .overflow(ovf[1])
    );

    logic_axi4_stream_packet_buffer #(
        .TDATA_BYTES(2), .TDEST_WIDTH(2), .TUSER_WIDTH(3), .TID_WIDTH(2),
        .USE_TLAST(1'b0), .USE_TKEEP(1'b0), .USE_TSTRB(1'b0),
        .CAPACITY(7), .PACKET_MODE(1'b1)
    ) u_nl (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
        .rx_tid(rx_tid), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
        .rx_tvalid(rx_tvalid), .rx_tready(rdy[2]),
        .tx_tdata(t_data[2]), .tx_tstrb(t_strb[2]), .tx_tkeep(t_keep[2]), .tx_tlast(t_last[2]),
        .tx_tid(t_id[2]), .tx_tdest(t_dest[2]), .tx_tuser(t_user[2]),
        .tx_tvalid(vld[2]), .tx_tready(tx_tready),
        .level(lvl2), .packets(pkt2), .overflow(ovf[2])
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Reference model: each DUT is an unbounded beat log; the stored beats are
    // those between the read count and the write count.
    logic [27:0] sb [ND][0:4095];
    int          wcnt [ND];
    int          rcnt [ND];
    bit          fz   [ND];
    bit          ov   [ND];
    bit          ren;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int stored_packets(input int d);
        int n = 0;
        for (int i = rcnt[d]; i < wcnt[d]; i++) n += int'(sb[d][i & 4095][7]);
        return n;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < ND; d++) begin
            wcnt[d] = 0; rcnt[d] = 0; fz[d] = 1'b0; ov[d] = 1'b0;
        end
        ren = 1'b0;
    endtask

    // Called at a negedge: checks outputs, drives one cycle of input, advances.
    task automatic step(input bit v, input logic [15:0] data, input bit last, input bit rd_rdy);
        int lv [ND];
        int pk [ND];
        bit fs [ND];
        bit ev [ND];
        bit wr [ND];
        bit rd [ND];
        logic [27:0] obs, beat;
        for (int d = 0; d < ND; d++) begin
            lv[d] = wcnt[d] - rcnt[d];
            pk[d] = stored_packets(d);
            fs[d] = pm_c[d] && lv[d] == cap_c[d] && pk[d] == 0;
            ev[d] = lv[d] != 0 && (!pm_c[d] || pk[d] != 0 || fz[d] || fs[d]);
            check($sformatf("d%0d level", d), 32'(lvl[d]), 32'(lv[d]));
            check($sformatf("d%0d packets", d), 32'(pkt[d]), 32'(pk[d]));
            check($sformatf("d%0d tx_tvalid", d), 32'(vld[d]), 32'(ev[d]));
            check($sformatf("d%0d rx_tready", d), 32'(rdy[d]), 32'(ren && lv[d] < cap_c[d]));
            check($sformatf("d%0d overflow", d), 32'(ovf[d]), 32'(ov[d] || fs[d]));
            if (ev[d]) begin
                obs = {t_data[d], t_strb[d], t_keep[d], t_last[d], t_id[d], t_dest[d], t_user[d]};
                check($sformatf("d%0d beat%0d", d, rcnt[d]), 32'(obs), 32'(sb[d][rcnt[d] & 4095]));
            end
        end
        rx_tvalid = v;
        rx_tdata  = data;
        rx_tlast  = last;
        rx_tstrb  = 2'($urandom);
        rx_tkeep  = 2'($urandom);
        rx_tid    = 2'($urandom);
        rx_tdest  = 2'($urandom);
        rx_tuser  = 3'($urandom);
        tx_tready = rd_rdy;
        for (int d = 0; d < ND; d++) begin
            wr[d] = v && ren && (lv[d] < cap_c[d]);
            rd[d] = ev[d] && rd_rdy;
            if (d == 2) beat = {data, 2'b11, 2'b11, 1'b1, rx_tid, rx_tdest, rx_tuser};
            else        beat = {data, rx_tstrb, rx_tkeep, last, rx_tid, rx_tdest, rx_tuser};
            if (wr[d]) sb[d][wcnt[d] & 4095] = beat;
        end
        @(posedge aclk);
        for (int d = 0; d < ND; d++) begin
            if (rd[d] && sb[d][rcnt[d] & 4095][7]) fz[d] = 1'b0;
            else if (fs[d])                        fz[d] = 1'b1;
            if (fs[d]) ov[d] = 1'b1;
            if (rd[d]) rcnt[d]++;
            if (wr[d]) wcnt[d]++;
        end
        ren = 1'b1;
        @(negedge aclk);
    endtask

    task automatic do_reset();
        rx_tvalid = 1'b0;
        areset_n  = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d rst tx_tvalid", d), 32'(vld[d]), 32'd0);
            check($sformatf("d%0d rst level", d), 32'(lvl[d]), 32'd0);
            check($sformatf("d%0d rst packets", d), 32'(pkt[d]), 32'd0);
            check($sformatf("d%0d rst overflow", d), 32'(ovf[d]), 32'd0);
            check($sformatf("d%0d rst rx_tready", d), 32'(rdy[d]), 32'd0);
        end
        model_clear();
        @(posedge aclk);
        @(negedge aclk);
        areset_n = 1'b1;
    endtask

    initial begin
        int p_v, p_r, p_l;
        areset_n = 1'b1;
        rx_tvalid = 1'b0; rx_tdata = '0; rx_tstrb = '0; rx_tkeep = '0; rx_tlast = 1'b0;
        rx_tid = '0; rx_tdest = '0; rx_tuser = '0; tx_tready = 1'b0;
        model_clear();
        #1;
        do_reset();

        // single beat, minimum latency
        step(1'b1, 16'h00A5, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

        // fill under backpressure, then drain
        for (int i = 0; i < 8; i++) step(1'b1, 16'(i), (i == 3 || i == 7), 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

        // store-and-forward 3-beat packet
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0100 + 16'(i), (i == 2), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

        // oversize 12-beat packet
        for (int i = 0; i < 12; i++) step(1'b1, 16'h0200 + 16'(i), (i == 11), 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

        // steady read+write at level 4 across pointer wrap
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0300 + 16'(i), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 16'h0310 + 16'(i), 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

        // reset in the middle of a packet, then a clean 2-beat packet
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
        do_reset();
        step(1'b1, 16'h0500, 1'b0, 1'b1);
        step(1'b1, 16'h0501, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

        // randomized traffic with changing pressure
        for (int blk = 0; blk < 12; blk++) begin
            p_v = $urandom_range(30, 95);
            p_r = $urandom_range(10, 95);
            p_l = $urandom_range(5, 40);
            for (int i = 0; i < 200; i++)
                step($urandom_range(0, 99) < p_v, 16'($urandom),
                     $urandom_range(0, 99) < p_l, $urandom_range(0, 99) < p_r);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
